// File: rtl/quote_filter.sv
// Quote output filter: per-stock change threshold and hold-off, crossed-quote rejection,
// and a first-word-fall-through FIFO toward order entry.
module quote_filter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_STOCKS = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int HOLD_WIDTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_data_valid,
   input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
   input  logic [DATA_WIDTH-1:0]         i_buy_price,
   input  logic [DATA_WIDTH-1:0]         i_sell_price,
   input  logic [DATA_WIDTH-1:0]         i_min_change,
   input  logic [HOLD_WIDTH-1:0]         i_hold_cycles,
   input  logic                          i_enable,
   input  logic                          i_quote_ready,
   output logic                          o_quote_valid,
   output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
   output logic [DATA_WIDTH-1:0]         o_buy_price,
   output logic [DATA_WIDTH-1:0]         o_sell_price,
   output logic                          o_fifo_full,
   output logic [15:0]                   o_drop_count
);

   localparam int ID_W  = $clog2(NUM_STOCKS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ID_W + 2 * DATA_WIDTH;

   function automatic logic [DATA_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   logic                  vld_p1;
   logic [ID_W-1:0]       id_p1;
   logic [DATA_WIDTH-1:0] buy_p1;
   logic [DATA_WIDTH-1:0] sell_p1;

   logic [NUM_STOCKS-1:0] tbl_vld;
   logic [DATA_WIDTH-1:0] tbl_buy  [NUM_STOCKS];
   logic [DATA_WIDTH-1:0] tbl_sell [NUM_STOCKS];
   logic [HOLD_WIDTH-1:0] tbl_hold [NUM_STOCKS];

   logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [15:0]           drop_cnt;

   logic                  ent_vld;
   logic [DATA_WIDTH-1:0] ent_buy;
   logic [DATA_WIDTH-1:0] ent_sell;
   logic [HOLD_WIDTH-1:0] ent_hold;
   logic                  moved;
   logic                  hold_clear;
   logic                  emit;
   logic                  pop;
   logic                  push_ok;
   logic                  push;
   logic                  drop;
   logic [ENT_W-1:0]      head;

   // Stage 1: capture
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) vld_p1 <= 1'b0;
      else         vld_p1 <= i_data_valid;
   end

   always_ff @(posedge i_clk) begin
      if (i_data_valid) begin
         id_p1   <= i_stock_id;
         buy_p1  <= i_buy_price;
         sell_p1 <= i_sell_price;
      end
   end

   // Stage 2: decide against the table, push or drop
   always_comb begin
      ent_vld    = tbl_vld[id_p1];
      ent_buy    = tbl_buy[id_p1];
      ent_sell   = tbl_sell[id_p1];
      ent_hold   = tbl_hold[id_p1];
      moved      = !ent_vld
                   || (abs_diff(buy_p1, ent_buy) >= i_min_change)
                   || (abs_diff(sell_p1, ent_sell) >= i_min_change);
      // A counter at 1 reaches zero on this very edge, so the stock is free again here.
      hold_clear = (ent_hold <= HOLD_WIDTH'(1));
      emit       = vld_p1 && i_enable && (buy_p1 < sell_p1) && hold_clear && moved;
   end

   assign pop     = (count != '0) && i_quote_ready;
   assign push_ok = (count < CNT_W'(FIFO_DEPTH)) || pop;
   assign push    = emit && push_ok;
   assign drop    = emit && !push_ok;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset || !i_enable) begin
         tbl_vld <= '0;
         for (int i = 0; i < NUM_STOCKS; i++) tbl_hold[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_STOCKS; i++) begin
            if (push && (id_p1 == ID_W'(i))) begin
               tbl_vld[i]  <= 1'b1;
               tbl_hold[i] <= i_hold_cycles;
            end else if (tbl_hold[i] != '0) begin
               tbl_hold[i] <= tbl_hold[i] - HOLD_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         tbl_buy[id_p1]   <= buy_p1;
         tbl_sell[id_p1]  <= sell_p1;
         fifo_mem[wr_ptr] <= {id_p1, buy_p1, sell_p1};
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
         if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Head fields read as zero while empty so reset and idle outputs are clean.
   assign head          = fifo_mem[rd_ptr];
   assign o_quote_valid = (count != '0);
   assign o_fifo_full   = (count == CNT_W'(FIFO_DEPTH));
   assign {o_stock_id, o_buy_price, o_sell_price} = o_quote_valid ? head : '0;
   assign o_drop_count  = drop_cnt;

endmodule

// File: tb/tb_quote_filter.sv
// Directed bench for quote_filter: threshold, hold-off, crossed quotes, overflow,
// enable toggle and asynchronous reset.
module tb_quote_filter;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_STOCKS = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int HOLD_WIDTH = 16;
   localparam int ID_W       = $clog2(NUM_STOCKS);

   logic                  clk;
   logic                  i_reset;
   logic                  i_data_valid;
   logic [ID_W-1:0]       i_stock_id;
   logic [DATA_WIDTH-1:0] i_buy_price;
   logic [DATA_WIDTH-1:0] i_sell_price;
   logic [DATA_WIDTH-1:0] i_min_change;
   logic [HOLD_WIDTH-1:0] i_hold_cycles;
   logic                  i_enable;
   logic                  i_quote_ready;
   logic                  o_quote_valid;
   logic [ID_W-1:0]       o_stock_id;
   logic [DATA_WIDTH-1:0] o_buy_price;
   logic [DATA_WIDTH-1:0] o_sell_price;
   logic                  o_fifo_full;
   logic [15:0]           o_drop_count;

   int n_checks;
   int n_errors;

   quote_filter #(
      .DATA_WIDTH(DATA_WIDTH), .NUM_STOCKS(NUM_STOCKS),
      .FIFO_DEPTH(FIFO_DEPTH), .HOLD_WIDTH(HOLD_WIDTH)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_data_valid(i_data_valid),
      .i_stock_id(i_stock_id), .i_buy_price(i_buy_price), .i_sell_price(i_sell_price),
      .i_min_change(i_min_change), .i_hold_cycles(i_hold_cycles), .i_enable(i_enable),
      .i_quote_ready(i_quote_ready), .o_quote_valid(o_quote_valid), .o_stock_id(o_stock_id),
      .o_buy_price(o_buy_price), .o_sell_price(o_sell_price), .o_fifo_full(o_fifo_full),
      .o_drop_count(o_drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_head(input string tag, input int id, input int buy, input int sell);
      check_val({tag, " valid"}, 64'(o_quote_valid), 64'd1);
      check_val({tag, " id"},    64'(o_stock_id),    64'(id));
      check_val({tag, " buy"},   64'(o_buy_price),   64'(buy));
      check_val({tag, " sell"},  64'(o_sell_price),  64'(sell));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int id, input int buy, input int sell);
      i_data_valid = 1'b1;
      i_stock_id   = ID_W'(id);
      i_buy_price  = DATA_WIDTH'(buy);
      i_sell_price = DATA_WIDTH'(sell);
   endtask

   // Quote sampled on the next edge; its decision happens one edge later.
   task automatic send(input int id, input int buy, input int sell);
      drive(id, buy, sell);
      tick();
      i_data_valid = 1'b0;
   endtask

   task automatic pop();
      i_quote_ready = 1'b1;
      tick();
      i_quote_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      i_reset       = 1'b1;
      i_data_valid  = 1'b0;
      i_stock_id    = '0;
      i_buy_price   = '0;
      i_sell_price  = '0;
      i_min_change  = 32'd5;
      i_hold_cycles = '0;
      i_enable      = 1'b1;
      i_quote_ready = 1'b0;
      tick();
      tick();
      check_val("reset valid", 64'(o_quote_valid), 64'd0);
      check_val("reset id",    64'(o_stock_id),    64'd0);
      check_val("reset buy",   64'(o_buy_price),   64'd0);
      check_val("reset sell",  64'(o_sell_price),  64'd0);
      check_val("reset full",  64'(o_fifo_full),   64'd0);
      check_val("reset drops", 64'(o_drop_count),  64'd0);
      i_reset = 1'b0;
      tick();

      // First quote and threshold suppression
      send(1, 100, 110);
      check_val("latency not yet", 64'(o_quote_valid), 64'd0);
      tick();
      check_head("first quote", 1, 100, 110);
      pop();
      check_val("drained", 64'(o_quote_valid), 64'd0);
      send(1, 103, 112);
      tick();
      check_val("below threshold", 64'(o_quote_valid), 64'd0);
      send(1, 105, 110);
      tick();
      check_head("buy moved 5", 1, 105, 110);
      pop();

      // Hold-off: new stock-2 quote every cycle, emissions 4 decisions apart
      i_min_change  = 32'd0;
      i_hold_cycles = 16'd4;
      for (int j = 0; j < 10; j++) begin
         drive(2, 10 + j, 100 + j);
         tick();
      end
      i_data_valid  = 1'b0;
      tick();
      i_hold_cycles = 16'd0;
      i_min_change  = 32'd5;
      for (int j = 0; j < 3; j++) begin
         check_head("hold emission", 2, 10 + 4 * j, 100 + 4 * j);
         pop();
      end
      check_val("hold only three", 64'(o_quote_valid), 64'd0);
      tick();
      tick();
      send(2, 22, 112);
      tick();
      check_val("table kept 18/108", 64'(o_quote_valid), 64'd0);
      send(2, 23, 108);
      tick();
      check_head("vs last emitted", 2, 23, 108);
      pop();

      // Crossed quote leaves the table untouched
      send(3, 200, 200);
      tick();
      check_val("locked quote", 64'(o_quote_valid), 64'd0);
      send(3, 199, 201);
      tick();
      check_head("after crossed", 3, 199, 201);
      pop();

      // Overflow with downstream stalled
      i_min_change = 32'd0;
      for (int j = 0; j < 10; j++) begin
         drive(0, j + 1, 1000 + j);
         tick();
      end
      i_data_valid = 1'b0;
      tick();
      check_val("overflow full",  64'(o_fifo_full),  64'd1);
      check_val("overflow drops", 64'(o_drop_count), 64'd2);
      check_head("overflow head", 0, 1, 1000);
      send(0, 50, 2000);
      i_quote_ready = 1'b1;
      tick();
      i_quote_ready = 1'b0;
      check_val("push with pop drops", 64'(o_drop_count), 64'd2);
      check_val("push with pop full",  64'(o_fifo_full),  64'd1);
      for (int j = 2; j <= 8; j++) begin
         check_head("fifo order", 0, j, 999 + j);
         pop();
      end
      check_head("late push", 0, 50, 2000);
      pop();
      check_val("overflow drained", 64'(o_quote_valid), 64'd0);

      // Enable toggle forces a re-quote
      i_min_change = 32'd5;
      send(0, 50, 60);
      tick();
      check_head("enable base", 0, 50, 60);
      pop();
      send(0, 50, 60);
      tick();
      check_val("identical suppressed", 64'(o_quote_valid), 64'd0);
      i_enable = 1'b0;
      tick();
      i_enable = 1'b1;
      send(0, 50, 60);
      tick();
      check_head("after re-enable", 0, 50, 60);
      pop();

      // Asynchronous reset mid-burst
      send(1, 300, 310);
      send(2, 400, 410);
      check_head("pre reset", 1, 300, 310);
      #2;
      i_reset = 1'b1;
      #1;
      check_val("async valid", 64'(o_quote_valid), 64'd0);
      check_val("async id",    64'(o_stock_id),    64'd0);
      check_val("async buy",   64'(o_buy_price),   64'd0);
      check_val("async sell",  64'(o_sell_price),  64'd0);
      check_val("async full",  64'(o_fifo_full),   64'd0);
      check_val("async drops", 64'(o_drop_count),  64'd0);
      #1;
      i_reset = 1'b0;
      tick();
      tick();
      check_val("staged quote lost", 64'(o_quote_valid), 64'd0);
      send(1, 300, 310);
      tick();
      check_head("first after reset", 1, 300, 310);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
